// File: rtl/uart_tx_buffer.sv
// Buffers MMU byte writes to the UART TX register in a local FIFO and drains them to the UART Lite.
// Define UART_TX_STATUS_VIRT_EN to merge local FIFO state into forwarded status reads.
module uart_tx_buffer #(
    parameter int         DEPTH_LOG2 = 11,
    parameter logic [3:0] TX_ADDR    = 4'h4,
    parameter logic [3:0] STAT_ADDR  = 4'h8,
    parameter int         TXFULL_BIT = 3
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [3:0]  mmu_axi_awaddr,
    input  logic [2:0]  mmu_axi_awprot,
    input  logic        mmu_axi_awvalid,
    output logic        mmu_axi_awready,
    input  logic [31:0] mmu_axi_wdata,
    input  logic [3:0]  mmu_axi_wstrb,
    input  logic        mmu_axi_wvalid,
    output logic        mmu_axi_wready,
    output logic [1:0]  mmu_axi_bresp,
    output logic        mmu_axi_bvalid,
    input  logic        mmu_axi_bready,
    input  logic [3:0]  mmu_axi_araddr,
    input  logic [2:0]  mmu_axi_arprot,
    input  logic        mmu_axi_arvalid,
    output logic        mmu_axi_arready,
    output logic [31:0] mmu_axi_rdata,
    output logic [1:0]  mmu_axi_rresp,
    output logic        mmu_axi_rvalid,
    input  logic        mmu_axi_rready,
    output logic [3:0]  uart_axi_awaddr,
    output logic [2:0]  uart_axi_awprot,
    output logic        uart_axi_awvalid,
    input  logic        uart_axi_awready,
    output logic [31:0] uart_axi_wdata,
    output logic [3:0]  uart_axi_wstrb,
    output logic        uart_axi_wvalid,
    input  logic        uart_axi_wready,
    input  logic [1:0]  uart_axi_bresp,
    input  logic        uart_axi_bvalid,
    output logic        uart_axi_bready,
    output logic [3:0]  uart_axi_araddr,
    output logic [2:0]  uart_axi_arprot,
    output logic        uart_axi_arvalid,
    input  logic        uart_axi_arready,
    input  logic [31:0] uart_axi_rdata,
    input  logic [1:0]  uart_axi_rresp,
    input  logic        uart_axi_rvalid,
    output logic        uart_axi_rready
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {W_IDLE, W_PUSH, W_FWD, W_RESP} wst_t;
    typedef enum logic [1:0] {R_IDLE, R_FWD, R_RESP} rst_t;
    typedef enum logic [2:0] {D_IDLE, D_POLL_AR, D_POLL_R, D_WR, D_B} dst_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_MMU, OWN_DRAIN} own_t;

    wst_t wstate;
    rst_t rstate;
    dst_t dstate;
    own_t wown, rown;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] head, tail;
    logic [DEPTH_LOG2:0]   count;
    logic                  full, do_push, do_pop, ub_hs, ur_hs;
    logic                  aw_got, w_got;
    logic [3:0]            aw_addr, w_strb, ar_addr;
    logic [2:0]            aw_prot, ar_prot;
    logic [31:0]           w_data, rdata_nxt;

    assign full    = count[DEPTH_LOG2];
    assign ub_hs   = uart_axi_bvalid && uart_axi_bready;
    assign ur_hs   = uart_axi_rvalid && uart_axi_rready;
    assign do_push = !full && w_strb[0] &&
                     ((wstate == W_IDLE && aw_got && w_got && aw_addr == TX_ADDR) || wstate == W_PUSH);
    assign do_pop  = dstate == D_B && wown == OWN_DRAIN && ub_hs;

    // Response ready only in the owner's response-wait state, after its address/data beats are gone.
    assign uart_axi_bready = ((wown == OWN_MMU && wstate == W_FWD) || (wown == OWN_DRAIN && dstate == D_B))
                             && !uart_axi_awvalid && !uart_axi_wvalid;
    assign uart_axi_rready = ((rown == OWN_MMU && rstate == R_FWD) || (rown == OWN_DRAIN && dstate == D_POLL_R))
                             && !uart_axi_arvalid;

    always_comb begin
        rdata_nxt = uart_axi_rdata;
`ifdef UART_TX_STATUS_VIRT_EN
        if (ar_addr == STAT_ADDR) begin
            rdata_nxt[TXFULL_BIT] = full;
            rdata_nxt[2]          = (count == '0) && uart_axi_rdata[2];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[head] <= w_data[7:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) head <= head + DEPTH_LOG2'(1);
            if (do_pop)  tail <= tail + DEPTH_LOG2'(1);
            count <= count + (DEPTH_LOG2+1)'(do_push) - (DEPTH_LOG2+1)'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wstate <= W_IDLE; mmu_axi_awready <= 1'b0; mmu_axi_wready <= 1'b0;
            mmu_axi_bvalid <= 1'b0; mmu_axi_bresp <= 2'b00;
            aw_got <= 1'b0; w_got <= 1'b0;
            aw_addr <= '0; aw_prot <= '0; w_data <= '0; w_strb <= '0;
        end else begin
            case (wstate)
                W_IDLE: begin
                    if (!aw_got) begin
                        if (mmu_axi_awvalid && mmu_axi_awready) begin
                            aw_got <= 1'b1; mmu_axi_awready <= 1'b0;
                            aw_addr <= mmu_axi_awaddr; aw_prot <= mmu_axi_awprot;
                        end else mmu_axi_awready <= 1'b1;
                    end
                    if (!w_got) begin
                        if (mmu_axi_wvalid && mmu_axi_wready) begin
                            w_got <= 1'b1; mmu_axi_wready <= 1'b0;
                            w_data <= mmu_axi_wdata; w_strb <= mmu_axi_wstrb;
                        end else mmu_axi_wready <= 1'b1;
                    end
                    if (aw_got && w_got) begin
                        if (aw_addr != TX_ADDR) wstate <= W_FWD;
                        else if (w_strb[0] && full) wstate <= W_PUSH;
                        else begin
                            mmu_axi_bvalid <= 1'b1; mmu_axi_bresp <= 2'b00; wstate <= W_RESP;
                        end
                    end
                end
                W_PUSH: if (!full) begin
                    mmu_axi_bvalid <= 1'b1; mmu_axi_bresp <= 2'b00; wstate <= W_RESP;
                end
                W_FWD: if (ub_hs && wown == OWN_MMU) begin
                    mmu_axi_bvalid <= 1'b1; mmu_axi_bresp <= uart_axi_bresp; wstate <= W_RESP;
                end
                default: if (mmu_axi_bready) begin
                    mmu_axi_bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
                    mmu_axi_awready <= 1'b1; mmu_axi_wready <= 1'b1; wstate <= W_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rstate <= R_IDLE; mmu_axi_arready <= 1'b0; mmu_axi_rvalid <= 1'b0;
            mmu_axi_rdata <= '0; mmu_axi_rresp <= 2'b00; ar_addr <= '0; ar_prot <= '0;
        end else begin
            case (rstate)
                R_IDLE: if (mmu_axi_arvalid && mmu_axi_arready) begin
                    ar_addr <= mmu_axi_araddr; ar_prot <= mmu_axi_arprot;
                    mmu_axi_arready <= 1'b0; rstate <= R_FWD;
                end else mmu_axi_arready <= 1'b1;
                R_FWD: if (ur_hs && rown == OWN_MMU) begin
                    mmu_axi_rdata <= rdata_nxt; mmu_axi_rresp <= uart_axi_rresp;
                    mmu_axi_rvalid <= 1'b1; rstate <= R_RESP;
                end
                default: if (mmu_axi_rready) begin
                    mmu_axi_rvalid <= 1'b0; mmu_axi_arready <= 1'b1; rstate <= R_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) dstate <= D_IDLE;
        else begin
            case (dstate)
                D_IDLE:    if (count != '0) dstate <= D_POLL_AR;
                D_POLL_AR: if (rown == OWN_DRAIN) dstate <= D_POLL_R;
                D_POLL_R:  if (ur_hs) dstate <= (uart_axi_rresp != 2'b00 || uart_axi_rdata[TXFULL_BIT]) ? D_IDLE : D_WR;
                D_WR:      if (wown == OWN_DRAIN) dstate <= D_B;
                default:   if (ub_hs) dstate <= D_IDLE;
            endcase
        end
    end

    // Non-preemptive channel owners; the MMU wins ties. Beats are loaded on the grant edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wown <= OWN_NONE; uart_axi_awvalid <= 1'b0; uart_axi_wvalid <= 1'b0;
            uart_axi_awaddr <= '0; uart_axi_awprot <= '0; uart_axi_wdata <= '0; uart_axi_wstrb <= '0;
        end else if (wown == OWN_NONE) begin
            if (wstate == W_FWD) begin
                wown <= OWN_MMU; uart_axi_awvalid <= 1'b1; uart_axi_wvalid <= 1'b1;
                uart_axi_awaddr <= aw_addr; uart_axi_awprot <= aw_prot;
                uart_axi_wdata <= w_data; uart_axi_wstrb <= w_strb;
            end else if (dstate == D_WR) begin
                wown <= OWN_DRAIN; uart_axi_awvalid <= 1'b1; uart_axi_wvalid <= 1'b1;
                uart_axi_awaddr <= TX_ADDR; uart_axi_awprot <= 3'b000;
                uart_axi_wdata <= {24'b0, mem[tail]}; uart_axi_wstrb <= 4'b0001;
            end
        end else begin
            if (uart_axi_awready) uart_axi_awvalid <= 1'b0;
            if (uart_axi_wready)  uart_axi_wvalid  <= 1'b0;
            if (ub_hs) wown <= OWN_NONE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rown <= OWN_NONE; uart_axi_arvalid <= 1'b0; uart_axi_araddr <= '0; uart_axi_arprot <= '0;
        end else if (rown == OWN_NONE) begin
            if (rstate == R_FWD) begin
                rown <= OWN_MMU; uart_axi_arvalid <= 1'b1;
                uart_axi_araddr <= ar_addr; uart_axi_arprot <= ar_prot;
            end else if (dstate == D_POLL_AR) begin
                rown <= OWN_DRAIN; uart_axi_arvalid <= 1'b1;
                uart_axi_araddr <= STAT_ADDR; uart_axi_arprot <= 3'b000;
            end
        end else begin
            if (uart_axi_arready) uart_axi_arvalid <= 1'b0;
            if (ur_hs) rown <= OWN_NONE;
        end
    end
endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer: MMU-side master tasks plus a small UART Lite responder model.
module tb_uart_tx_buffer;
    logic clk = 1'b0, rstn = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  mmu_axi_awaddr = '0, mmu_axi_araddr = '0, mmu_axi_wstrb = '0;
    logic [2:0]  mmu_axi_awprot = '0, mmu_axi_arprot = '0;
    logic [31:0] mmu_axi_wdata = '0;
    logic        mmu_axi_awvalid = 1'b0, mmu_axi_wvalid = 1'b0, mmu_axi_bready = 1'b0;
    logic        mmu_axi_arvalid = 1'b0, mmu_axi_rready = 1'b0;
    logic        mmu_axi_awready, mmu_axi_wready, mmu_axi_bvalid, mmu_axi_arready, mmu_axi_rvalid;
    logic [1:0]  mmu_axi_bresp, mmu_axi_rresp;
    logic [31:0] mmu_axi_rdata;

    logic [3:0]  uart_axi_awaddr, uart_axi_wstrb, uart_axi_araddr;
    logic [2:0]  uart_axi_awprot, uart_axi_arprot;
    logic [31:0] uart_axi_wdata;
    logic        uart_axi_awvalid, uart_axi_wvalid, uart_axi_bready, uart_axi_arvalid, uart_axi_rready;
    logic        uart_axi_awready = 1'b1, uart_axi_wready = 1'b1, uart_axi_arready = 1'b1;
    logic        uart_axi_bvalid = 1'b0, uart_axi_rvalid = 1'b0;
    logic [1:0]  uart_axi_bresp = '0, uart_axi_rresp = '0;
    logic [31:0] uart_axi_rdata = '0;

    uart_tx_buffer dut (
        .clk(clk), .rstn(rstn),
        .mmu_axi_awaddr(mmu_axi_awaddr), .mmu_axi_awprot(mmu_axi_awprot),
        .mmu_axi_awvalid(mmu_axi_awvalid), .mmu_axi_awready(mmu_axi_awready),
        .mmu_axi_wdata(mmu_axi_wdata), .mmu_axi_wstrb(mmu_axi_wstrb),
        .mmu_axi_wvalid(mmu_axi_wvalid), .mmu_axi_wready(mmu_axi_wready),
        .mmu_axi_bresp(mmu_axi_bresp), .mmu_axi_bvalid(mmu_axi_bvalid), .mmu_axi_bready(mmu_axi_bready),
        .mmu_axi_araddr(mmu_axi_araddr), .mmu_axi_arprot(mmu_axi_arprot),
        .mmu_axi_arvalid(mmu_axi_arvalid), .mmu_axi_arready(mmu_axi_arready),
        .mmu_axi_rdata(mmu_axi_rdata), .mmu_axi_rresp(mmu_axi_rresp),
        .mmu_axi_rvalid(mmu_axi_rvalid), .mmu_axi_rready(mmu_axi_rready),
        .uart_axi_awaddr(uart_axi_awaddr), .uart_axi_awprot(uart_axi_awprot),
        .uart_axi_awvalid(uart_axi_awvalid), .uart_axi_awready(uart_axi_awready),
        .uart_axi_wdata(uart_axi_wdata), .uart_axi_wstrb(uart_axi_wstrb),
        .uart_axi_wvalid(uart_axi_wvalid), .uart_axi_wready(uart_axi_wready),
        .uart_axi_bresp(uart_axi_bresp), .uart_axi_bvalid(uart_axi_bvalid), .uart_axi_bready(uart_axi_bready),
        .uart_axi_araddr(uart_axi_araddr), .uart_axi_arprot(uart_axi_arprot),
        .uart_axi_arvalid(uart_axi_arvalid), .uart_axi_arready(uart_axi_arready),
        .uart_axi_rdata(uart_axi_rdata), .uart_axi_rresp(uart_axi_rresp),
        .uart_axi_rvalid(uart_axi_rvalid), .uart_axi_rready(uart_axi_rready)
    );

    // UART responder: logs every completed write as {addr, strb, data} and every read address.
    logic        got_aw = 1'b0, got_w = 1'b0;
    logic [3:0]  m_aw, m_ws;
    logic [31:0] m_wd;
    logic [1:0]  bresp_cfg = 2'b00;
    logic [31:0] rd_cfg = '0, stat_def = 32'h4;
    logic [31:0] stat_q[$];
    logic [39:0] wlog[$];
    logic [3:0]  rlog[$];

    always @(posedge clk) begin
        if (uart_axi_awvalid && uart_axi_awready) begin m_aw <= uart_axi_awaddr; got_aw <= 1'b1; end
        if (uart_axi_wvalid && uart_axi_wready) begin m_wd <= uart_axi_wdata; m_ws <= uart_axi_wstrb; got_w <= 1'b1; end
        if (got_aw && got_w && !uart_axi_bvalid) begin
            uart_axi_bvalid <= 1'b1; uart_axi_bresp <= bresp_cfg;
            wlog.push_back({m_aw, m_ws, m_wd}); got_aw <= 1'b0; got_w <= 1'b0;
        end
        if (uart_axi_bvalid && uart_axi_bready) uart_axi_bvalid <= 1'b0;
        if (uart_axi_arvalid && uart_axi_arready) begin
            rlog.push_back(uart_axi_araddr);
            uart_axi_rvalid <= 1'b1; uart_axi_rresp <= 2'b00;
            if (uart_axi_araddr == 4'h8) uart_axi_rdata <= (stat_q.size() > 0) ? stat_q.pop_front() : stat_def;
            else uart_axi_rdata <= rd_cfg;
        end else if (uart_axi_rvalid && uart_axi_rready) uart_axi_rvalid <= 1'b0;
    end

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [39:0] wl(input int i);
        if (i < wlog.size()) return wlog[i];
        return '1;
    endfunction

    function automatic logic [3:0] rl(input int i);
        if (i < rlog.size()) return rlog[i];
        return 4'hF;
    endfunction

    function automatic int polls();
        int n = 0;
        foreach (rlog[i]) if (rlog[i] == 4'h8) n++;
        return n;
    endfunction

    // Called at a negedge; returns at the negedge after the later of the aw/w handshakes.
    task automatic wr_issue(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s, output bit ok);
        bit ah = 0, wh = 0;
        int n = 0;
        mmu_axi_awaddr = a; mmu_axi_wdata = d; mmu_axi_wstrb = s;
        mmu_axi_awvalid = 1'b1; mmu_axi_wvalid = 1'b1;
        while (!(ah && wh) && n < 200) begin
            if (mmu_axi_awvalid && mmu_axi_awready) ah = 1;
            if (mmu_axi_wvalid && mmu_axi_wready) wh = 1;
            @(negedge clk); n++;
            if (ah) mmu_axi_awvalid = 1'b0;
            if (wh) mmu_axi_wvalid = 1'b0;
        end
        mmu_axi_awvalid = 1'b0; mmu_axi_wvalid = 1'b0;
        ok = ah && wh;
    endtask

    task automatic wr_resp(input int tmo, output logic [1:0] resp, output int lat);
        lat = 0;
        while (!mmu_axi_bvalid && lat < tmo) begin @(negedge clk); lat++; end
        resp = mmu_axi_bresp;
        if (mmu_axi_bvalid) begin mmu_axi_bready = 1'b1; @(negedge clk); mmu_axi_bready = 1'b0; end
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d, output logic [1:0] r, output bit ok);
        bit hs = 0;
        int n = 0;
        mmu_axi_araddr = a; mmu_axi_arvalid = 1'b1;
        while (!hs && n < 200) begin hs = mmu_axi_arready; @(negedge clk); n++; end
        mmu_axi_arvalid = 1'b0; n = 0;
        while (!mmu_axi_rvalid && n < 200) begin @(negedge clk); n++; end
        ok = mmu_axi_rvalid; d = mmu_axi_rdata; r = mmu_axi_rresp;
        if (mmu_axi_rvalid) begin mmu_axi_rready = 1'b1; @(negedge clk); mmu_axi_rready = 1'b0; end
    endtask

    task automatic wait_wlog(input int n, input int tmo, output bit ok);
        int c = 0;
        while (wlog.size() < n && c < tmo) begin @(negedge clk); c++; end
        ok = wlog.size() >= n;
    endtask

    initial begin
        bit ok, ok2;
        int lat, bad;
        logic [1:0] resp, rr;
        logic [31:0] d;

        repeat (2) @(negedge clk);
        chk("rst_awready", mmu_axi_awready, 0);
        chk("rst_bvalid", mmu_axi_bvalid, 0);
        chk("rst_uart_awvalid", uart_axi_awvalid, 0);
        chk("rst_uart_arvalid", uart_axi_arvalid, 0);
        rstn = 1'b1;
        @(negedge clk);
        chk("awready_up", mmu_axi_awready, 1);
        chk("wready_up", mmu_axi_wready, 1);
        chk("arready_up", mmu_axi_arready, 1);

        // Buffered byte, then drained after a clean status poll.
        wr_issue(4'h4, 32'h41, 4'hF, ok);
        wr_resp(20, resp, lat);
        chk("t1_lat", lat, 1);
        chk("t1_bresp", resp, 2'b00);
        wait_wlog(1, 200, ok);
        repeat (3) @(negedge clk);
        chk("t1_drain_beat", wl(0), {4'h4, 4'h1, 32'h41});
        chk("t1_poll_addr", rl(0), 4'h8);
        chk("t1_count", dut.count, 0);

        // Three full polls before a clear one.
        wlog.delete(); rlog.delete();
        stat_q = '{32'h8, 32'h8, 32'h8, 32'h4};
        wr_issue(4'h4, 32'h5A, 4'hF, ok);
        wr_resp(20, resp, lat);
        wait_wlog(1, 300, ok);
        repeat (20) @(negedge clk);
        chk("t2_polls", polls(), 4);
        chk("t2_writes", wlog.size(), 1);
        chk("t2_byte", wl(0), {4'h4, 4'h1, 32'h5A});

        // Fill the FIFO with the poll stalled; the 2049th write waits for the first pop.
        wlog.delete(); rlog.delete();
        uart_axi_arready = 1'b0;
        bad = 0;
        for (int i = 0; i < 2048; i++) begin
            wr_issue(4'h4, i, 4'hF, ok);
            wr_resp(20, resp, lat);
            if (!ok || lat != 1 || resp != 2'b00) bad++;
        end
        chk("t3_all_answered", bad, 0);
        wr_issue(4'h4, 32'd2048, 4'hF, ok);
        wr_resp(30, resp, lat);
        chk("t3_full_no_bvalid", lat, 30);
        uart_axi_arready = 1'b1;
        wr_resp(100, resp, lat);
        chk("t3_bvalid_after_pop", lat < 100, 1);
        wait_wlog(2049, 60000, ok);
        chk("t3_nbytes", wlog.size(), 2049);
        bad = 0;
        for (int i = 0; i < 2049; i++) if (wl(i) !== {4'h4, 4'h1, 24'h0, i[7:0]}) bad++;
        chk("t3_order", bad, 0);

        // MMU read and drain poll requested in the same cycle.
        repeat (5) @(negedge clk);
        wlog.delete(); rlog.delete();
        rd_cfg = 32'hAB;
        fork
            begin wr_issue(4'h4, 32'h77, 4'hF, ok); wr_resp(20, resp, lat); end
            begin repeat (2) @(negedge clk); rd(4'h0, d, rr, ok2); end
        join
        wait_wlog(1, 200, ok);
        repeat (3) @(negedge clk);
        chk("t4_first_ar", rl(0), 4'h0);
        chk("t4_second_ar", rl(1), 4'h8);
        chk("t4_rdata", d, 32'hAB);
        chk("t4_rresp", rr, 2'b00);
        chk("t4_byte", wl(0), {4'h4, 4'h1, 32'h77});

        // Forwarded write with an error response.
        wlog.delete(); rlog.delete();
        bresp_cfg = 2'b10;
        wr_issue(4'hC, 32'h3, 4'h5, ok);
        wr_resp(50, resp, lat);
        chk("t5_bresp", resp, 2'b10);
        chk("t5_beat", wl(0), {4'hC, 4'h5, 32'h3});
        bresp_cfg = 2'b00;

        // Reset while the drain write address is stalled.
        wlog.delete(); rlog.delete();
        uart_axi_awready = 1'b0;
        wr_issue(4'h4, 32'h99, 4'hF, ok);
        wr_resp(20, resp, lat);
        lat = 0;
        while (!uart_axi_awvalid && lat < 100) begin @(negedge clk); lat++; end
        chk("t6_awvalid_seen", uart_axi_awvalid, 1);
        rstn = 1'b0;
        #1;
        chk("t6_rst_awvalid", uart_axi_awvalid, 0);
        chk("t6_rst_wvalid", uart_axi_wvalid, 0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        chk("t6_count", dut.count, 0);
        uart_axi_awready = 1'b1;
        repeat (50) @(negedge clk);
        chk("t6_no_writes", wlog.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
